arbiter_rr_param: RTL and testbench

//  Parametrised N-way bus arbiter; successor to fixed 3/4-way strict and round-robin arbiters.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/arb_rr_pick.sv | 37 +++
 rtl/arbiter_rr_param.sv | 101 ++++++++++
 tb/tb_arbiter_rr_param.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-way bus arbiter (arbiter_rr_param).
package arb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    localparam int ARB_MODE_STRICT = 0;
    localparam int ARB_MODE_RR     = 1;

    // Returns the index of the set bit; the result is only meaningful for a one-hot input.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] i_oh);
        logic [3:0] r_idx;
        r_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (i_oh[i]) r_idx = r_idx | 4'(i);
        end
        return r_idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner pick: rotate requests by the start index, take the lowest set bit, rotate back.
// Zero latency; there is no flow control (pure function of its inputs).
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_start,
    output logic [NUM_REQ-1:0] o_win_oh,
    output logic [IW-1:0]      o_win_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_rot_oh;
    logic [NUM_REQ-1:0] w_win_oh;

    always_comb begin
        w_rot    = '0;
        w_win_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rot[i] = i_req[(i + int'(i_start)) % NUM_REQ];
        end
        // Isolate the lowest set bit of the rotated vector.
        w_rot_oh = w_rot & (~w_rot + NUM_REQ'(1));
        for (int k = 0; k < NUM_REQ; k++) begin
            w_win_oh[(k + int'(i_start)) % NUM_REQ] = w_rot_oh[k];
        end
    end

    assign o_win_oh  = w_win_oh;
    assign o_win_idx = IW'(onehot_to_idx(16'(w_win_oh)));
    assign o_any     = |i_req;

endmodule

// File: rtl/arbiter_rr_param.sv
// N-way bus arbiter: strict priority or round-robin, grant held until end of access (optional ARB_TIMEOUT_EN).
// Request-to-grant takes 1 cycle; handover on release happens with no idle cycle; a request waits as long as the owner holds.
module arbiter_rr_param
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 255,
    parameter int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [NUM_REQ-1:0] end_access_vec,
    output logic [NUM_REQ-1:0] gnt_vec,
    output logic [IW-1:0]      gnt_id,
    output logic               gnt_valid,
    output logic               timeout_pulse
);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt_vec;
    logic [IW-1:0]      r_gnt_id;
    logic [IW-1:0]      r_last;

    logic [IW-1:0]      w_start;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IW-1:0]      w_pick_idx;
    logic               w_any;
    logic               w_owner_end;
    logic               w_timeout;
    logic               w_release;
    logic               w_new_grant;

    always_comb begin
        w_start = '0;
        if (MODE == ARB_MODE_RR) begin
            w_start = (r_last == IW'(NUM_REQ - 1)) ? '0 : r_last + 1'b1;
        end
    end

    arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .i_req     (req_vec),
        .i_start   (w_start),
        .o_win_oh  (w_pick_oh),
        .o_win_idx (w_pick_idx),
        .o_any     (w_any)
    );

    // Only the current owner's end_access bit counts.
    assign w_owner_end = |(end_access_vec & r_gnt_vec);
    assign w_release   = (r_state == ARB_GRANTED) && (w_owner_end || w_timeout);
    assign w_new_grant = w_any && ((r_state == ARB_IDLE) || w_release);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [CW-1:0] r_hold_cnt;

    assign w_timeout = (r_state == ARB_GRANTED) && !w_owner_end &&
                       (r_hold_cnt == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else if (w_new_grant) begin
            r_hold_cnt <= '0;
        end else if (r_state == ARB_GRANTED) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_gnt_vec <= '0;
            r_gnt_id  <= '0;
            r_last    <= IW'(NUM_REQ - 1);
        end else if (w_new_grant) begin
            r_state   <= ARB_GRANTED;
            r_gnt_vec <= w_pick_oh;
            r_gnt_id  <= w_pick_idx;
            r_last    <= w_pick_idx;
        end else if (w_release) begin
            r_state   <= ARB_IDLE;
            r_gnt_vec <= '0;
            r_gnt_id  <= '0;
        end
    end

    assign gnt_vec       = r_gnt_vec;
    assign gnt_id        = r_gnt_id;
    assign gnt_valid     = |r_gnt_vec;
    assign timeout_pulse = w_timeout;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Bench for arbiter_rr_param: a round-robin and a strict-priority instance share the same stimulus.
module tb_arbiter_rr_param;

    logic       clk;
    logic       reset;
    logic [3:0] req_vec;
    logic [3:0] end_access_vec;

    logic [3:0] rr_gnt, sp_gnt;
    logic [1:0] rr_id, sp_id;
    logic       rr_vld, sp_vld, rr_to, sp_to;

    int n_checks = 0;
    int n_errors = 0;

    arbiter_rr_param #(.NUM_REQ(4), .MODE(1), .MAX_HOLD(8)) u_rr (
        .clk(clk), .reset(reset), .req_vec(req_vec), .end_access_vec(end_access_vec),
        .gnt_vec(rr_gnt), .gnt_id(rr_id), .gnt_valid(rr_vld), .timeout_pulse(rr_to)
    );

    arbiter_rr_param #(.NUM_REQ(4), .MODE(0), .MAX_HOLD(8)) u_sp (
        .clk(clk), .reset(reset), .req_vec(req_vec), .end_access_vec(end_access_vec),
        .gnt_vec(sp_gnt), .gnt_id(sp_id), .gnt_valid(sp_vld), .timeout_pulse(sp_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] endv;
        logic [3:0] exp_rr;
        logic [3:0] exp_sp;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_rr, input logic [3:0] e_sp,
                           input logic e_to_rr, input logic e_to_sp);
        chk({tag, " rr gnt_vec"},   32'(rr_gnt), 32'(e_rr));
        chk({tag, " rr gnt_id"},    32'(rr_id),  32'(idx_of(e_rr)));
        chk({tag, " rr gnt_valid"}, 32'(rr_vld), 32'(|e_rr));
        chk({tag, " rr timeout"},   32'(rr_to),  32'(e_to_rr));
        chk({tag, " sp gnt_vec"},   32'(sp_gnt), 32'(e_sp));
        chk({tag, " sp gnt_id"},    32'(sp_id),  32'(idx_of(e_sp)));
        chk({tag, " sp gnt_valid"}, 32'(sp_vld), 32'(|e_sp));
        chk({tag, " sp timeout"},   32'(sp_to),  32'(e_to_sp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            req      end      rr       sp
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0001};
        tbl[2]  = '{4'b1111, 4'b1111, 4'b0010, 4'b0001};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001};
        tbl[4]  = '{4'b1111, 4'b1111, 4'b0100, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0001};
        tbl[6]  = '{4'b1111, 4'b1111, 4'b1000, 4'b0001};
        tbl[7]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0001};
        tbl[8]  = '{4'b1111, 4'b1111, 4'b0001, 4'b0001};
        tbl[9]  = '{4'b1010, 4'b1110, 4'b0001, 4'b0001};
        tbl[10] = '{4'b1010, 4'b0001, 4'b0010, 4'b0010};
        tbl[11] = '{4'b1010, 4'b1111, 4'b1000, 4'b0010};
        tbl[12] = '{4'b1010, 4'b1111, 4'b0010, 4'b0010};
        tbl[13] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100};
        tbl[16] = '{4'b0000, 4'b0001, 4'b0100, 4'b0100};
        tbl[17] = '{4'b1001, 4'b0100, 4'b1000, 4'b0001};
        tbl[18] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};

        reset          = 1'b1;
        req_vec        = 4'b0000;
        end_access_vec = 4'b0000;
        step();
        step();
        chk_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;

        for (int v = 0; v < 19; v++) begin
            req_vec        = tbl[v].req;
            end_access_vec = tbl[v].endv;
            step();
            chk_all($sformatf("vec%0d", v), tbl[v].exp_rr, tbl[v].exp_sp, 1'b0, 1'b0);
        end

        // Asynchronous reset while master 2 owns both arbiters.
        req_vec        = 4'b0100;
        end_access_vec = 4'b0000;
        step();
        chk_all("pre-reset", 4'b0100, 4'b0100, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_all("async reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step();
        req_vec = 4'b0000;
        reset   = 1'b0;
        step();
        step();
        chk_all("idle after reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        req_vec = 4'b1001;
        step();
        chk_all("pointer reset", 4'b0001, 4'b0001, 1'b0, 1'b0);

        // Long hold: owners never signal end of access.
        end_access_vec = 4'b1111;
        req_vec        = 4'b0000;
        step();
        chk_all("drain", 4'b0000, 4'b0000, 1'b0, 1'b0);
        end_access_vec = 4'b0000;
        req_vec        = 4'b0011;
        step();
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            chk_all($sformatf("hold cyc%0d", c), 4'b0010, 4'b0001, c == 8, c == 8);
            step();
        end
        chk_all("after timeout", 4'b0001, 4'b0001, 1'b0, 1'b0);
`else
        for (int c = 1; c <= 9; c++) begin
            chk_all($sformatf("hold cyc%0d", c), 4'b0010, 4'b0001, 1'b0, 1'b0);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
